// File: rtl/seg7_pkg.sv
// Shared types and constants for the seven-segment scan display: FSM state
// encoding, special segment patterns and the digit-to-segment encoder.
package seg7_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_SHIFT   = 2'd2,
    ST_COMMIT  = 2'd3
  } seg7_state_e;

  // Segment order {a,b,c,d,e,f,g}, active-low.
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b1111110;

  function automatic logic [6:0] seg_encode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b0000001;
      4'd1:    s = 7'b1001111;
      4'd2:    s = 7'b0010010;
      4'd3:    s = 7'b0000110;
      4'd4:    s = 7'b1001100;
      4'd5:    s = 7'b0100100;
      4'd6:    s = 7'b0100000;
      4'd7:    s = 7'b0001111;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0000100;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary-to-BCD converter: one CAPTURE cycle, DATA_W
// SHIFT cycles, one COMMIT cycle. bcd/ovf are the working values, valid while done.
module bin2bcd_seq
  import seg7_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_W-1:0]     din,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  ovf,
  output seg7_state_e           state_dbg
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  // Handshake: start is a level request, accepted only in IDLE; busy is high
  // from CAPTURE through COMMIT; done is a one-cycle pulse during COMMIT.
  seg7_state_e            state_q, state_d;
  logic [DATA_W-1:0]      bin_q, bin_d;
  logic [4*DIGITS-1:0]    acc_q, acc_d, adj;
  logic                   ovf_work_q, ovf_work_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (start) state_d = ST_CAPTURE;
      ST_CAPTURE: state_d = ST_SHIFT;
      ST_SHIFT:   if (cnt_q == CNT_W'(1)) state_d = ST_COMMIT;
      ST_COMMIT:  state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q != ST_IDLE);
    done      = (state_q == ST_COMMIT);
    state_dbg = state_q;
    bcd       = acc_q;
    ovf       = ovf_work_q;
  end

  always_comb begin
    adj = acc_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    bin_d      = bin_q;
    acc_d      = acc_q;
    ovf_work_d = ovf_work_q;
    cnt_d      = cnt_q;
    case (state_q)
      ST_CAPTURE: begin
        bin_d      = din;
        acc_d      = '0;
        ovf_work_d = 1'b0;
        cnt_d      = CNT_W'(DATA_W);
      end
      ST_SHIFT: begin
        // The bit leaving the top digit is a carry into 10^DIGITS.
        {acc_d, bin_d} = {adj, bin_q} << 1;
        ovf_work_d     = ovf_work_q | adj[4*DIGITS-1];
        cnt_d          = cnt_q - CNT_W'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q      <= '0;
      acc_q      <= '0;
      ovf_work_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      bin_q      <= bin_d;
      acc_q      <= acc_d;
      ovf_work_q <= ovf_work_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule

// File: rtl/seg7_scan_display.sv
// Multiplexed seven-segment driver: channel select, periodic BCD re-conversion,
// digit scanning. Define SEG7_LEADING_ZERO_BLANK_EN to blank leading zeros.
module seg7_scan_display
  import seg7_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int NCH         = 4,
  parameter int DIGITS      = 4,
  parameter int SCAN_DIV    = 100000,
  parameter int REFRESH_DIV = 1000000
) (
  input  logic                      clk_pre,
  input  logic                      reset,
  input  logic [NCH*DATA_W-1:0]     ch_data,
  input  logic [$clog2(NCH)-1:0]    ch_sel,
  output logic [DIGITS-1:0]         an,
  output logic [6:0]                seg,
  output logic [4*DIGITS-1:0]       bcd_out,
  output logic                      ovf,
  output logic                      busy,
  output seg7_state_e               state_dbg
);

  localparam int SEL_W  = $clog2(NCH);
  localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int REF_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  logic [SEL_W-1:0]     sel_q, sel_d, sel_eff;
  logic [REF_W-1:0]     ref_cnt_q, ref_cnt_d;
  logic [SCAN_W-1:0]    scan_cnt_q, scan_cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 pend_q, pend_d;
  logic [4*DIGITS-1:0]  bcd_q, bcd_d;
  logic                 ovf_q, ovf_d;
  logic [DIGITS-1:0]    an_q, an_d;
  logic [6:0]           seg_q, seg_d;

  logic                 req, start;
  logic                 eng_busy, eng_done, eng_ovf;
  logic [4*DIGITS-1:0]  eng_bcd;
  logic [3:0]           cur_digit;
  logic                 lead_blank;

  bin2bcd_seq #(.DATA_W(DATA_W), .DIGITS(DIGITS)) u_bin2bcd (
    .clk       (clk_pre),
    .rst_n     (reset),
    .start     (start),
    .din       (ch_data[sel_q*DATA_W +: DATA_W]),
    .busy      (eng_busy),
    .done      (eng_done),
    .bcd       (eng_bcd),
    .ovf       (eng_ovf),
    .state_dbg (state_dbg)
  );

  always_comb begin
    sel_eff = (int'(ch_sel) < NCH) ? ch_sel : '0;
    sel_d   = sel_eff;
    // A select change and a refresh tick in the same cycle merge into one request.
    req     = (sel_eff != sel_q) || (ref_cnt_q == REF_W'(REFRESH_DIV - 1));
    start   = req || pend_q;
    pend_d  = eng_busy ? (pend_q || req) : 1'b0;

    ref_cnt_d  = (ref_cnt_q == REF_W'(REFRESH_DIV - 1)) ? '0 : ref_cnt_q + REF_W'(1);
    scan_cnt_d = (scan_cnt_q == SCAN_W'(SCAN_DIV - 1)) ? '0 : scan_cnt_q + SCAN_W'(1);
    idx_d      = idx_q;
    if (scan_cnt_q == SCAN_W'(SCAN_DIV - 1))
      idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);

    bcd_d = eng_done ? eng_bcd : bcd_q;
    ovf_d = eng_done ? eng_ovf : ovf_q;
  end

  always_comb begin
    cur_digit  = bcd_q[idx_q*4 +: 4];
    lead_blank = 1'b0;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    lead_blank = (idx_q != '0);
    for (int j = 0; j < DIGITS; j++) begin
      if (j >= int'(idx_q) && bcd_q[4*j +: 4] != 4'd0) lead_blank = 1'b0;
    end
`endif
    an_d = ~(DIGITS'(1) << idx_q);
    if (ovf_q)           seg_d = SEG_DASH;
    else if (lead_blank) seg_d = SEG_BLANK;
    else                 seg_d = seg_encode(cur_digit);
  end

  always_ff @(posedge clk_pre or negedge reset) begin
    if (!reset) begin
      sel_q      <= '0;
      ref_cnt_q  <= '0;
      scan_cnt_q <= '0;
      idx_q      <= '0;
      pend_q     <= 1'b0;
      bcd_q      <= '0;
      ovf_q      <= 1'b0;
      an_q       <= ~DIGITS'(1);
      seg_q      <= 7'b0000001;
    end else begin
      sel_q      <= sel_d;
      ref_cnt_q  <= ref_cnt_d;
      scan_cnt_q <= scan_cnt_d;
      idx_q      <= idx_d;
      pend_q     <= pend_d;
      bcd_q      <= bcd_d;
      ovf_q      <= ovf_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
    end
  end

  assign an      = an_q;
  assign seg     = seg_q;
  assign bcd_out = bcd_q;
  assign ovf     = ovf_q;
  assign busy    = eng_busy;

endmodule

// File: tb/tb_seg7_scan_display.sv
// Directed bench for seg7_scan_display: conversion latency, scanning, blanking,
// overflow dashes, back-to-back requests and mid-conversion reset.
module tb_seg7_scan_display;
  import seg7_pkg::*;

  localparam int DATA_W = 32, NCH = 4, DIGITS = 4, SCAN_DIV = 4, REFRESH_DIV = 64;

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  localparam logic [6:0] LZ = 7'b1111111;
`else
  localparam logic [6:0] LZ = 7'b0000001;
`endif

  logic                   clk_pre = 1'b0;
  logic                   reset   = 1'b0;
  logic [NCH*DATA_W-1:0]  ch_data = '0;
  logic [1:0]             ch_sel  = 2'd1;
  logic [DIGITS-1:0]      an;
  logic [6:0]             seg;
  logic [4*DIGITS-1:0]    bcd_out;
  logic                   ovf, busy;
  seg7_state_e            state_dbg;

  int n_cmp = 0;
  int n_bad = 0;

  seg7_scan_display #(
    .DATA_W(DATA_W), .NCH(NCH), .DIGITS(DIGITS),
    .SCAN_DIV(SCAN_DIV), .REFRESH_DIV(REFRESH_DIV)
  ) dut (
    .clk_pre   (clk_pre),
    .reset     (reset),
    .ch_data   (ch_data),
    .ch_sel    (ch_sel),
    .an        (an),
    .seg       (seg),
    .bcd_out   (bcd_out),
    .ovf       (ovf),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_pre = ~clk_pre;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk_pre);
    #1;
  endtask

  task automatic set_ch(input int k, input logic [DATA_W-1:0] v);
    ch_data[k*DATA_W +: DATA_W] = v;
  endtask

  task automatic wait_rise(input int bound, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      tick(1);
      if (busy === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Waits until the converter has stayed idle for three cycles in a row.
  task automatic wait_settle(input int bound, output logic ok);
    int idle;
    idle = 0;
    ok   = 1'b0;
    for (int i = 0; i < bound; i++) begin
      tick(1);
      if (busy === 1'b0) idle++;
      else idle = 0;
      if (idle == 3) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Records the segment pattern seen for each enabled digit over 17 cycles;
  // bad flags a non one-hot enable or a dwell other than SCAN_DIV cycles.
  task automatic capture_scan(output logic [27:0] segs, output logic [3:0] seen, output logic bad);
    logic [3:0] prev_an;
    int last_chg;
    segs = '1;
    seen = '0;
    bad  = 1'b0;
    last_chg = -1;
    prev_an = 4'bxxxx;
    for (int c = 0; c < 17; c++) begin
      tick(1);
      case (an)
        4'b1110: begin segs[6:0]   = seg; seen[0] = 1'b1; end
        4'b1101: begin segs[13:7]  = seg; seen[1] = 1'b1; end
        4'b1011: begin segs[20:14] = seg; seen[2] = 1'b1; end
        4'b0111: begin segs[27:21] = seg; seen[3] = 1'b1; end
        default: bad = 1'b1;
      endcase
      if (c > 0 && an !== prev_an) begin
        if (last_chg >= 0 && (c - last_chg) != SCAN_DIV) bad = 1'b1;
        last_chg = c;
      end
      prev_an = an;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    set_ch(1, 32'd1234);
    ch_sel = 2'd1;
    reset  = 1'b0;
    tick(3);
    n_cmp++; if (an !== 4'b1110) begin n_bad++; $display("FAIL reset_an: got %b want 1110", an); end
    n_cmp++; if (seg !== 7'b0000001) begin n_bad++; $display("FAIL reset_seg: got %b want 0000001", seg); end
    n_cmp++; if (bcd_out !== 16'h0000) begin n_bad++; $display("FAIL reset_bcd: got %h want 0000", bcd_out); end
    n_cmp++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL reset_ovf: got %b want 0", ovf); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (state_dbg !== ST_IDLE) begin n_bad++; $display("FAIL reset_state: got %0d want 0", state_dbg); end
    reset = 1'b1;
  endtask

  task automatic test_convert;
    logic [27:0] segs;
    logic [3:0]  seen;
    logic        bad;
    logic [6:0]  exp_seg [4];
    exp_seg = '{7'b1001100, 7'b0000110, 7'b0010010, 7'b1001111};
    // Select change 0 -> 1 requests on the first edge after release.
    tick(1);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL conv_busy_start: got %b want 1", busy); end
    tick(33);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL conv_busy_commit: got %b want 1", busy); end
    n_cmp++; if (bcd_out !== 16'h0000) begin n_bad++; $display("FAIL conv_bcd_early: got %h want 0000", bcd_out); end
    tick(1);
    n_cmp++; if (bcd_out !== 16'h1234) begin n_bad++; $display("FAIL conv_bcd: got %h want 1234", bcd_out); end
    n_cmp++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL conv_ovf: got %b want 0", ovf); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL conv_busy_end: got %b want 0", busy); end
    tick(2);
    capture_scan(segs, seen, bad);
    n_cmp++; if ({seen, bad} !== 5'b11110) begin n_bad++; $display("FAIL conv_scan: seen %b bad %b want 1111 0", seen, bad); end
    for (int d = 0; d < 4; d++) begin
      n_cmp++;
      if (segs[d*7 +: 7] !== exp_seg[d]) begin
        n_bad++; $display("FAIL conv_seg%0d: got %b want %b", d, segs[d*7 +: 7], exp_seg[d]);
      end
    end
  endtask

  task automatic test_blank;
    logic [27:0] segs;
    logic [3:0]  seen;
    logic        bad, ok1, ok2;
    logic [6:0]  exp_seg [4];
    exp_seg = '{7'b0000001, 7'b0000000, LZ, LZ};
    set_ch(0, 32'd80);
    ch_sel = 2'd0;
    wait_rise(10, ok1);
    wait_settle(200, ok2);
    n_cmp++; if ({ok1, ok2} !== 2'b11) begin n_bad++; $display("FAIL blank_wait: got %b want 11", {ok1, ok2}); end
    n_cmp++; if (bcd_out !== 16'h0080) begin n_bad++; $display("FAIL blank_bcd: got %h want 0080", bcd_out); end
    capture_scan(segs, seen, bad);
    n_cmp++; if ({seen, bad} !== 5'b11110) begin n_bad++; $display("FAIL blank_scan: seen %b bad %b want 1111 0", seen, bad); end
    for (int d = 0; d < 4; d++) begin
      n_cmp++;
      if (segs[d*7 +: 7] !== exp_seg[d]) begin
        n_bad++; $display("FAIL blank_seg%0d: got %b want %b", d, segs[d*7 +: 7], exp_seg[d]);
      end
    end
  endtask

  task automatic test_ovf;
    logic [27:0] segs;
    logic [3:0]  seen;
    logic        bad, ok1, ok2;
    set_ch(2, 32'd10000);
    ch_sel = 2'd2;
    wait_rise(10, ok1);
    wait_settle(200, ok2);
    n_cmp++; if ({ok1, ok2} !== 2'b11) begin n_bad++; $display("FAIL ovf_wait: got %b want 11", {ok1, ok2}); end
    n_cmp++; if (ovf !== 1'b1) begin n_bad++; $display("FAIL ovf_flag: got %b want 1", ovf); end
    n_cmp++; if (bcd_out !== 16'h0000) begin n_bad++; $display("FAIL ovf_bcd_mod: got %h want 0000", bcd_out); end
    capture_scan(segs, seen, bad);
    n_cmp++; if ({seen, bad} !== 5'b11110) begin n_bad++; $display("FAIL ovf_scan: seen %b bad %b want 1111 0", seen, bad); end
    n_cmp++; if (segs !== {4{7'b1111110}}) begin n_bad++; $display("FAIL ovf_dash: got %h want %h", segs, {4{7'b1111110}}); end
    // No select change: the next refresh tick picks up the new value.
    set_ch(2, 32'd9999);
    wait_rise(80, ok1);
    wait_settle(200, ok2);
    n_cmp++; if ({ok1, ok2} !== 2'b11) begin n_bad++; $display("FAIL refresh_wait: got %b want 11", {ok1, ok2}); end
    n_cmp++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL refresh_ovf: got %b want 0", ovf); end
    n_cmp++; if (bcd_out !== 16'h9999) begin n_bad++; $display("FAIL refresh_bcd: got %h want 9999", bcd_out); end
    capture_scan(segs, seen, bad);
    n_cmp++; if (segs !== {4{7'b0000100}}) begin n_bad++; $display("FAIL refresh_seg: got %h want %h", segs, {4{7'b0000100}}); end
  endtask

  task automatic test_back_to_back;
    logic ok1, ok2;
    set_ch(1, 32'd4321);
    set_ch(3, 32'd5678);
    ch_sel = 2'd1;
    wait_rise(10, ok1);
    n_cmp++; if (ok1 !== 1'b1) begin n_bad++; $display("FAIL b2b_start: got %b want 1", ok1); end
    tick(9);
    ch_sel = 2'd3;
    set_ch(1, 32'd1111);
    tick(24);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL b2b_busy1: got %b want 1", busy); end
    n_cmp++; if (bcd_out !== 16'h9999) begin n_bad++; $display("FAIL b2b_hold: got %h want 9999", bcd_out); end
    tick(1);
    n_cmp++; if (bcd_out !== 16'h4321) begin n_bad++; $display("FAIL b2b_first: got %h want 4321", bcd_out); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL b2b_gap: got %b want 0", busy); end
    tick(1);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL b2b_restart: got %b want 1", busy); end
    tick(33);
    n_cmp++; if (bcd_out !== 16'h4321) begin n_bad++; $display("FAIL b2b_hold2: got %h want 4321", bcd_out); end
    tick(1);
    n_cmp++; if (bcd_out !== 16'h5678) begin n_bad++; $display("FAIL b2b_second: got %h want 5678", bcd_out); end
    wait_settle(200, ok2);
    n_cmp++; if (ok2 !== 1'b1) begin n_bad++; $display("FAIL b2b_settle: got %b want 1", ok2); end
  endtask

  task automatic test_reset_mid;
    logic ok1;
    set_ch(0, 32'd7);
    ch_sel = 2'd0;
    wait_rise(10, ok1);
    n_cmp++; if (ok1 !== 1'b1) begin n_bad++; $display("FAIL rmid_start: got %b want 1", ok1); end
    tick(15);
    reset = 1'b0;
    #1;
    n_cmp++; if (an !== 4'b1110) begin n_bad++; $display("FAIL rmid_an: got %b want 1110", an); end
    n_cmp++; if (seg !== 7'b0000001) begin n_bad++; $display("FAIL rmid_seg: got %b want 0000001", seg); end
    n_cmp++; if (bcd_out !== 16'h0000) begin n_bad++; $display("FAIL rmid_bcd: got %h want 0000", bcd_out); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rmid_busy: got %b want 0", busy); end
    tick(3);
    n_cmp++; if ({busy, bcd_out} !== 17'h0) begin n_bad++; $display("FAIL rmid_hold: got %h want 0", {busy, bcd_out}); end
    reset = 1'b1;
    tick(63);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rmid_quiet: got %b want 0", busy); end
    tick(1);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL rmid_refresh: got %b want 1", busy); end
    tick(34);
    n_cmp++; if (bcd_out !== 16'h0007) begin n_bad++; $display("FAIL rmid_bcd_after: got %h want 0007", bcd_out); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rmid_busy_after: got %b want 0", busy); end
  endtask

  task automatic test_zero;
    logic [27:0] segs;
    logic [3:0]  seen;
    logic        bad, ok1, ok2;
    logic [6:0]  exp_seg [4];
    exp_seg = '{7'b0000001, LZ, LZ, LZ};
    set_ch(1, 32'd0);
    ch_sel = 2'd1;
    wait_rise(10, ok1);
    wait_settle(200, ok2);
    n_cmp++; if ({ok1, ok2} !== 2'b11) begin n_bad++; $display("FAIL zero_wait: got %b want 11", {ok1, ok2}); end
    n_cmp++; if ({ovf, bcd_out} !== 17'h0) begin n_bad++; $display("FAIL zero_bcd: got %h want 0", {ovf, bcd_out}); end
    capture_scan(segs, seen, bad);
    n_cmp++; if ({seen, bad} !== 5'b11110) begin n_bad++; $display("FAIL zero_scan: seen %b bad %b want 1111 0", seen, bad); end
    for (int d = 0; d < 4; d++) begin
      n_cmp++;
      if (segs[d*7 +: 7] !== exp_seg[d]) begin
        n_bad++; $display("FAIL zero_seg%0d: got %b want %b", d, segs[d*7 +: 7], exp_seg[d]);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    @(posedge clk_pre);
    #1;
    test_reset;
    test_convert;
    test_blank;
    test_ovf;
    test_back_to_back;
    test_reset_mid;
    test_zero;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
